// File: rtl/multicycle_main_control_if.sv
// multicycle_main_control_if: opcode/memory handshake in, datapath control strobes out
interface multicycle_main_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic [3:0] state_o;
  logic       illegal_op;
  logic       mem_timeout;
  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_o, illegal_op, mem_timeout
  );
  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, state_o, illegal_op, mem_timeout
  );
endinterface

// File: rtl/multicycle_main_control.sv
// multicycle_main_control: multicycle MIPS main control FSM with memory watchdog; CTRL_ADDI_EN adds ADDI
module multicycle_main_control #(
  parameter int unsigned WDOG_W     = 8,
  parameter int unsigned WDOG_LIMIT = 255
) (
  input logic clk,
  input logic rst,
  multicycle_main_control_if.master bus
);
  localparam logic [5:0] OP_RT = 6'b000000;
  localparam logic [5:0] OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_J = 6'b000010;
`ifdef CTRL_ADDI_EN
  localparam logic [5:0] OP_ADDI = 6'b001000;
`endif
  localparam logic [WDOG_W-1:0] LIM = WDOG_LIMIT[WDOG_W-1:0];
  typedef enum logic [3:0] {
    IDLE = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEM_ADDR = 4'd3, MEM_READ = 4'd4,
    MEM_WB = 4'd5, MEM_WRITE = 4'd6, EXECUTE = 4'd7, R_WB = 4'd8, BRANCH = 4'd9,
`ifdef CTRL_ADDI_EN
    ADDI_EXEC = 4'd11, ADDI_WB = 4'd12,
`endif
    JUMP = 4'd10
  } state_t;
  state_t st, dec_nxt;
  logic [WDOG_W-1:0] wd;
  logic op_sw, waiting, tmo, addi_exec, addi_wb;
  assign waiting = st == FETCH || st == MEM_READ || st == MEM_WRITE;
  assign tmo = waiting && !bus.mem_ready && wd == LIM;
`ifdef CTRL_ADDI_EN
  assign addi_exec = st == ADDI_EXEC;
  assign addi_wb = st == ADDI_WB;
`else
  assign addi_exec = 1'b0;
  assign addi_wb = 1'b0;
`endif
  // opcode dispatch out of DECODE; unsupported opcodes fall back to FETCH
  always_comb
    dec_nxt = bus.opcode == OP_RT ? EXECUTE :
              (bus.opcode == OP_LW || bus.opcode == OP_SW) ? MEM_ADDR :
              bus.opcode == OP_BEQ ? BRANCH :
              bus.opcode == OP_J ? JUMP :
`ifdef CTRL_ADDI_EN
              bus.opcode == OP_ADDI ? ADDI_EXEC :
`endif
              FETCH;
  // state sequencing, memory-wait watchdog and load/store choice captured in DECODE
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      wd <= '0;
      op_sw <= 1'b0;
    end else begin
      wd <= (waiting && !bus.mem_ready && !tmo) ? wd + 1'b1 : '0;
      if (st == DECODE) op_sw <= bus.opcode == OP_SW;
      case (st)
        IDLE:      st <= FETCH;
        FETCH:     st <= bus.mem_ready ? DECODE : FETCH;
        DECODE:    st <= dec_nxt;
        MEM_ADDR:  st <= op_sw ? MEM_WRITE : MEM_READ;
        MEM_READ:  st <= tmo ? FETCH : bus.mem_ready ? MEM_WB : MEM_READ;
        MEM_WRITE: st <= (tmo || bus.mem_ready) ? FETCH : MEM_WRITE;
        EXECUTE:   st <= R_WB;
`ifdef CTRL_ADDI_EN
        ADDI_EXEC: st <= ADDI_WB;
`endif
        MEM_WB, R_WB, BRANCH, JUMP: st <= FETCH;
        default:   st <= FETCH;
      endcase
    end
  assign bus.state_o = st;
  assign bus.mem_read = st == FETCH || st == MEM_READ;
  assign bus.i_or_d = st == MEM_READ || st == MEM_WRITE;
  assign bus.mem_write = st == MEM_WRITE;
  assign bus.ir_write = st == FETCH && bus.mem_ready;
  assign bus.pc_write = (st == FETCH && bus.mem_ready) || st == JUMP;
  assign bus.pc_write_cond = st == BRANCH;
  assign bus.mem_to_reg = st == MEM_WB;
  assign bus.reg_dst = st == R_WB;
  assign bus.reg_write = st == MEM_WB || st == R_WB || addi_wb;
  assign bus.alu_src_a = st == MEM_ADDR || st == EXECUTE || st == BRANCH || addi_exec;
  assign bus.alu_src_b = st == FETCH ? 2'b01 : st == DECODE ? 2'b11 :
                         (st == MEM_ADDR || addi_exec) ? 2'b10 : 2'b00;
  assign bus.alu_op = st == EXECUTE ? 2'b10 : st == BRANCH ? 2'b01 : 2'b00;
  assign bus.pc_source = st == BRANCH ? 2'b01 : st == JUMP ? 2'b10 : 2'b00;
  assign bus.illegal_op = st == DECODE && dec_nxt == FETCH;
  assign bus.mem_timeout = tmo;
endmodule
